pwm_spi_multi: RTL

//  Multi-channel successor to the single-LED serial-load PWM. Serial frames (address + duty),

---
 rtl/pwm_spi_multi.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pwm_spi_multi.sv
// pwm_spi_multi: serial frames (address + duty, LSB first) load per-channel shadow duty;
// each channel's PWM picks it up at the period wrap. Optional readback via PWM_READBACK_EN.
`timescale 1ns/1ps
module pwm_spi_multi #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned CLK_DIV    = 1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_err
`ifdef PWM_READBACK_EN
  ,
  output logic                data_out
`endif
);

  localparam int unsigned FRAME = ADDR_W + WIDTH;
  localparam int unsigned CW    = $clog2(FRAME + 2);
  localparam logic [WIDTH-1:0] CNT_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

  // S_BLOCK holds off after reset until enable has been seen low
  typedef enum logic [1:0] {S_BLOCK, S_IDLE, S_SHIFT} rx_state_e;

  rx_state_e         state_q, state_d;
  logic              shift_en, commit;
  logic [CW-1:0]     count_q;
  logic [FRAME-1:0]  frame_q;
  logic [ADDR_W-1:0] frm_addr, last_addr_q;
  logic [WIDTH-1:0]  frm_duty;
  logic              frame_ok, frame_err_q;
  logic [WIDTH-1:0]  shadow_q [CHANNELS];
  logic [WIDTH-1:0]  active_q [CHANNELS];
  logic [15:0]       div_q;
  logic              tick;
  logic [WIDTH-1:0]  cnt_q;
  logic [CHANNELS-1:0] pwm_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_BLOCK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BLOCK: if (!enable) state_d = S_IDLE;
      S_IDLE:  if (enable)  state_d = S_SHIFT;
      S_SHIFT: if (!enable) state_d = S_IDLE;
      default: state_d = S_BLOCK;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      S_IDLE:  shift_en = enable;
      S_SHIFT: begin
        shift_en = enable;
        commit   = !enable;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      frame_q <= '0;
    end else if (commit) begin
      count_q <= '0;
    end else if (shift_en) begin
      for (int unsigned i = 0; i < FRAME; i++)
        if (count_q == CW'(i)) frame_q[i] <= data;
      if (count_q < CW'(FRAME + 1)) count_q <= count_q + 1'b1;
    end
  end

  assign frm_addr = frame_q[ADDR_W-1:0];
  assign frm_duty = frame_q[FRAME-1:ADDR_W];
  assign frame_ok = (count_q == CW'(FRAME)) && (32'(frm_addr) < CHANNELS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) shadow_q[i] <= '0;
      last_addr_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= commit && !frame_ok;
      if (commit && frame_ok) begin
        for (int unsigned i = 0; i < CHANNELS; i++)
          if (frm_addr == ADDR_W'(i)) shadow_q[i] <= frm_duty;
        last_addr_q <= frm_addr;
      end
    end
  end

  assign tick = (div_q == 16'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) active_q[i] <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        if (cnt_q == CNT_MAX) begin
          cnt_q <= '0;
          // nonblocking read: a commit on this same edge applies one period later
          for (int unsigned i = 0; i < CHANNELS; i++) active_q[i] <= shadow_q[i];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= ACTIVE_LOW ? '1 : '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++)
        pwm_q[i] <= (cnt_q < active_q[i]) ^ ACTIVE_LOW;
    end
  end

  assign pwm_out   = pwm_q;
  assign frame_err = frame_err_q;

`ifdef PWM_READBACK_EN
  logic [FRAME-1:0] rb_q, rb_load;
  logic [WIDTH-1:0] rb_duty;
  logic             rb_bit_q;

  always_comb begin
    rb_duty = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      if (last_addr_q == ADDR_W'(i)) rb_duty = shadow_q[i];
    rb_load = {rb_duty, last_addr_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_q     <= '0;
      rb_bit_q <= 1'b0;
    end else if (shift_en && state_q == S_IDLE) begin
      rb_bit_q <= rb_load[0];
      rb_q     <= rb_load >> 1;
    end else if (shift_en) begin
      rb_bit_q <= rb_q[0];
      rb_q     <= rb_q >> 1;
    end else begin
      rb_bit_q <= 1'b0;
    end
  end

  assign data_out = rb_bit_q;
`endif

endmodule
